// File: rtl/rr_arbiter4.sv
// Four-client round-robin arbiter with a one-hot grant, a grant index and an
// optional per-tenure hold limit that forces release and pulses timeout.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int unsigned N_CLIENTS = 4;
  localparam int unsigned IDX_W     = 2;
  localparam bit          HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_n;
  logic [IDX_W-1:0]   grant_idx_n;
  logic               grant_valid_n;
  logic               timeout_n;
  logic [3:0]         grant_n;

  logic [IDX_W-1:0]   pick_idx_c;
  logic               pick_found_c;
  logic [IDX_W-1:0]   cand_c;

  // Rotating priority search starting at ptr; the first requester found wins.
  always_comb begin
    pick_idx_c   = ptr;
    pick_found_c = 1'b0;
    cand_c       = ptr;
    for (int i = 0; i < N_CLIENTS; i++) begin
      cand_c = ptr + IDX_W'(i);
      if (!pick_found_c && req[cand_c]) begin
        pick_idx_c   = cand_c;
        pick_found_c = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    hold_cnt_n    = hold_cnt;
    grant_idx_n   = grant_idx;
    grant_valid_n = grant_valid;
    timeout_n     = 1'b0;
    grant_n       = 4'b0000;

    unique case (state)
      IDLE: begin
        if (pick_found_c) begin
          grant_idx_n   = pick_idx_c;
          grant_valid_n = 1'b1;
          hold_cnt_n    = '0;
          state_n       = GRANT;
        end else begin
          grant_valid_n = 1'b0;
        end
      end
      GRANT: begin
        // A dropped request on the limit edge counts as a plain release.
        if (!req[grant_idx]) begin
          state_n       = IDLE;
          grant_valid_n = 1'b0;
          ptr_n         = grant_idx + IDX_W'(1);
        end else if (HOLD_EN && (hold_cnt == HOLD_LAST)) begin
          state_n       = IDLE;
          grant_valid_n = 1'b0;
          ptr_n         = grant_idx + IDX_W'(1);
          timeout_n     = 1'b1;
        end else if (hold_cnt != {CNT_W{1'b1}}) begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n       = IDLE;
        grant_valid_n = 1'b0;
      end
    endcase

    if (grant_valid_n) begin
      grant_n = 4'b0001 << grant_idx_n;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= 4'b0000;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      hold_cnt    <= hold_cnt_n;
      grant       <= grant_n;
      grant_idx   <= grant_idx_n;
      grant_valid <= grant_valid_n;
      timeout     <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Randomized and directed stimulus on three arbiter instances (hold limits
// 4, unlimited and 1) compared each cycle against a tenure-level model.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] grant     [3];
  logic [1:0] grant_idx [3];
  logic       grant_valid [3];
  logic       timeout   [3];

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Model state per instance: owner -1 means nobody holds the resource.
  int hold_lim [3] = '{4, 0, 1};
  int m_owner  [3];
  int m_held   [3];
  int m_next   [3];
  int m_idx    [3];
  bit m_to     [3];

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) u_h4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant[0]), .grant_idx(grant_idx[0]),
    .grant_valid(grant_valid[0]), .timeout(timeout[0])
  );

  rr_arbiter4 #(.MAX_HOLD(0), .CNT_W(8)) u_h0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant[1]), .grant_idx(grant_idx[1]),
    .grant_valid(grant_valid[1]), .timeout(timeout[1])
  );

  rr_arbiter4 #(.MAX_HOLD(1), .CNT_W(4)) u_h1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant[2]), .grant_idx(grant_idx[2]),
    .grant_valid(grant_valid[2]), .timeout(timeout[2])
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_owner[k] = -1;
      m_held[k]  = 0;
      m_next[k]  = 0;
      m_idx[k]   = 0;
      m_to[k]    = 1'b0;
    end
  endtask

  // One clock edge of the arbitration rules, in tenure terms.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      m_to[k] = 1'b0;
      if (m_owner[k] < 0) begin
        for (int j = 0; j < 4; j++) begin
          int c;
          c = (m_next[k] + j) % 4;
          if (m_owner[k] < 0 && req[c]) begin
            m_owner[k] = c;
            m_idx[k]   = c;
            m_held[k]  = 1;
          end
        end
      end else if (!req[m_owner[k]]) begin
        m_next[k]  = (m_owner[k] + 1) % 4;
        m_owner[k] = -1;
      end else if (hold_lim[k] != 0 && m_held[k] == hold_lim[k]) begin
        m_next[k]  = (m_owner[k] + 1) % 4;
        m_owner[k] = -1;
        m_to[k]    = 1'b1;
      end else begin
        m_held[k]++;
      end
    end
  endtask

  task automatic compare_all(input string phase);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] exp_g;
      exp_g = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
      check_val($sformatf("%s.i%0d.grant", phase, k), 32'(grant[k]), 32'(exp_g));
      check_val($sformatf("%s.i%0d.idx", phase, k), 32'(grant_idx[k]), 32'(m_idx[k]));
      check_val($sformatf("%s.i%0d.valid", phase, k), 32'(grant_valid[k]),
                32'(m_owner[k] >= 0));
      check_val($sformatf("%s.i%0d.timeout", phase, k), 32'(timeout[k]), 32'(m_to[k]));
    end
  endtask

  task automatic step(input string phase, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all(phase);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;

    // Single request held three cycles.
    req = 4'b0100;
    step("single", 3);
    req = 4'b0000;
    step("single_rel", 2);

    // Rotation: serve 1, then 0011 searches from 2.
    req = 4'b0010;
    step("rot_a", 2);
    req = 4'b0000;
    step("rot_b", 1);
    req = 4'b0011;
    step("rot_c", 2);
    check_val("rot_first_pick", 32'(grant[1]), 32'h1);
    req = 4'b0000;
    step("rot_d", 1);
    req = 4'b0011;
    step("rot_e", 2);
    check_val("rot_second_pick", 32'(grant[1]), 32'h2);
    req = 4'b0000;
    step("rot_f", 2);

    // Async reset in the middle of a tenure on client 2.
    req = 4'b0100;
    step("pre_rst", 2);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    #1 rst_n = 1'b1;
    req = 4'b1111;
    step("post_rst", 1);
    check_val("post_rst_first", 32'(grant[0]), 32'h1);

    // Saturation with everyone requesting.
    step("saturate", 45);
    req = 4'b0000;
    step("sat_rel", 2);

    // Request drops on the edge where the limit is reached.
    req = 4'b0001;
    step("simul_hold", 4);
    req = 4'b0000;
    step("simul_drop", 1);
    check_val("simul_no_timeout", 32'(timeout[0]), 32'h0);
    step("simul_idle", 1);

    // Unlimited hold: client 3 keeps the resource, client 0 waits.
    req = 4'b1000;
    step("unlim_a", 150);
    req = 4'b1001;
    step("unlim_b", 150);
    check_val("unlim_held", 32'(grant[1]), 32'h8);
    req = 4'b0001;
    step("unlim_c", 4);

    // Random traffic: mostly sticky requests with occasional bit flips.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = req ^ (4'b0001 << $urandom_range(0, 3));
      end
      if ($urandom_range(0, 63) == 0) begin
        req = 4'($urandom_range(0, 15));
      end
      step("random", 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
